reorder_buffer: RTL and testbench

Circular reorder buffer of the Tomasulo core, directly upstream of the commit stage. Allocates one entry per dispatched instruction in program order, collects results from the ALU and LSB writeback buses, and presents the head entry to commit once it is ready. Pops the head when commit fires and flushes every entry when commit signals a branch misprediction.

---
 rtl/reorder_buffer_pkg.sv | 38 +++
 rtl/reorder_buffer_query_port.sv | 39 +++
 rtl/reorder_buffer.sv | 139 +++++++++++++
 tb/tb_reorder_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: depth, tag width,
// instruction id / address widths, the entry record and a pointer helper.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH  = 16;
   localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
   localparam int INSTR_ID_W = 6;
   localparam int ADDR_W     = 32;

   localparam logic [ROB_IDX_W:0] ROB_CNT_FULL = (ROB_IDX_W+1)'(ROB_DEPTH);
   localparam logic [ROB_IDX_W:0] ROB_CNT_ONE  = (ROB_IDX_W+1)'(1);

   // A few decoded instruction ids used by upstream decode
   localparam logic [INSTR_ID_W-1:0] INSTR_NOP = INSTR_ID_W'(0);
   localparam logic [INSTR_ID_W-1:0] INSTR_ADD = INSTR_ID_W'(1);
   localparam logic [INSTR_ID_W-1:0] INSTR_LW  = INSTR_ID_W'(2);
   localparam logic [INSTR_ID_W-1:0] INSTR_SW  = INSTR_ID_W'(3);
   localparam logic [INSTR_ID_W-1:0] INSTR_BEQ = INSTR_ID_W'(4);

   typedef logic [ROB_IDX_W-1:0]  rob_idx_t;
   typedef logic [INSTR_ID_W-1:0] instr_id_t;

   typedef struct packed {
      logic              busy;
      logic              ready;
      instr_id_t         instr_id;
      logic [4:0]        rd;
      logic [31:0]       value;
      logic              jump_en;
      logic [ADDR_W-1:0] jump_a;
   } rob_entry_t;

   // Pointers wrap naturally because the depth is a power of two
   function automatic rob_idx_t idx_inc(input rob_idx_t idx);
      return idx + ROB_IDX_W'(1);
   endfunction

endpackage

// File: rtl/reorder_buffer_query_port.sv
// Operand read port of the reorder buffer. Selects the stored ready/value
// of the queried tag; with ROB_BYPASS_EN defined it also forwards results
// present on the ALU/LSB writeback buses this cycle (ALU has priority).
module reorder_buffer_query_port
   import reorder_buffer_pkg::*;
(
   input  logic [ROB_DEPTH-1:0] busy_vec_i,
   input  logic [ROB_DEPTH-1:0] ready_vec_i,
   input  logic [31:0]          value_arr_i [ROB_DEPTH],
   input  rob_idx_t             query_tag_i,
`ifdef ROB_BYPASS_EN
   input  logic                 alu_wb_en_i,
   input  rob_idx_t             alu_wb_tag_i,
   input  logic [31:0]          alu_wb_value_i,
   input  logic                 lsb_wb_en_i,
   input  rob_idx_t             lsb_wb_tag_i,
   input  logic [31:0]          lsb_wb_value_i,
`endif
   output logic                 query_ready_o,
   output logic [31:0]          query_value_o
);

   // Stored state first, then same-cycle bus forwarding overrides it
   always_comb begin
      query_ready_o = busy_vec_i[query_tag_i] && ready_vec_i[query_tag_i];
      query_value_o = value_arr_i[query_tag_i];
`ifdef ROB_BYPASS_EN
      if (lsb_wb_en_i && (lsb_wb_tag_i == query_tag_i)) begin
         query_ready_o = 1'b1;
         query_value_o = lsb_wb_value_i;
      end
      if (alu_wb_en_i && (alu_wb_tag_i == query_tag_i)) begin
         query_ready_o = 1'b1;
         query_value_o = alu_wb_value_i;
      end
`endif
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer feeding the commit stage. Entries are allocated
// in program order at the tail, completed by the ALU/LSB writeback buses
// and retired from the head. Optional macro: ROB_BYPASS_EN (query port
// forwards same-cycle writeback results).
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              dispatch_en_in,
   input  instr_id_t         dispatch_instr_id_in,
   input  logic [4:0]        dispatch_rd_in,
   output rob_idx_t          dispatch_tag_out,
   output logic              rob_full_out,
   input  logic              alu_wb_en_in,
   input  rob_idx_t          alu_wb_tag_in,
   input  logic [31:0]       alu_wb_value_in,
   input  logic              alu_wb_jump_en_in,
   input  logic [ADDR_W-1:0] alu_wb_jump_a_in,
   input  logic              lsb_wb_en_in,
   input  rob_idx_t          lsb_wb_tag_in,
   input  logic [31:0]       lsb_wb_value_in,
   input  rob_idx_t          query_tag_in,
   output logic              query_ready_out,
   output logic [31:0]       query_value_out,
   output logic              rob_to_commit_en_out,
   output instr_id_t         commit_instr_id_out,
   output logic [4:0]        commit_rd_out,
   output logic [31:0]       commit_value_out,
   output logic              commit_jump_en_out,
   output logic [ADDR_W-1:0] commit_jump_a_out,
   output rob_idx_t          commit_tag_out,
   input  logic              clear_branch_in
);

   rob_entry_t           entry_q [ROB_DEPTH];
   rob_idx_t             head_q, tail_q;
   logic [ROB_IDX_W:0]   count_q, count_d;
   rob_entry_t           head_entry;
   logic                 dispatch_fire, commit_fire;
   logic                 alu_wb_hit, lsb_wb_hit;
   logic [ROB_DEPTH-1:0] busy_vec, ready_vec;
   logic [31:0]          value_arr [ROB_DEPTH];

   assign head_entry           = entry_q[head_q];
   assign rob_full_out         = (count_q == ROB_CNT_FULL);
   assign dispatch_tag_out     = tail_q;
   assign rob_to_commit_en_out = rdy_in && (count_q != '0) && head_entry.busy && head_entry.ready;
   assign commit_fire          = rob_to_commit_en_out;
   // No pop-through: a full buffer refuses dispatch even while the head retires
   assign dispatch_fire        = rdy_in && dispatch_en_in && !rob_full_out;
   assign alu_wb_hit           = alu_wb_en_in && entry_q[alu_wb_tag_in].busy;
   // ALU wins if both buses name the same tag
   assign lsb_wb_hit           = lsb_wb_en_in && entry_q[lsb_wb_tag_in].busy &&
                                 !(alu_wb_en_in && (alu_wb_tag_in == lsb_wb_tag_in));

   assign commit_instr_id_out  = head_entry.instr_id;
   assign commit_rd_out        = head_entry.rd;
   assign commit_value_out     = head_entry.value;
   assign commit_jump_en_out   = head_entry.jump_en;
   assign commit_jump_a_out    = head_entry.jump_a;
   assign commit_tag_out       = head_q;

   genvar gi;
   generate
      for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_flat
         assign busy_vec[gi]  = entry_q[gi].busy;
         assign ready_vec[gi] = entry_q[gi].ready;
         assign value_arr[gi] = entry_q[gi].value;
      end
   endgenerate

   // Occupancy: simultaneous dispatch and commit leave it unchanged
   always_comb begin
      count_d = count_q;
      if (dispatch_fire && !commit_fire)
         count_d = count_q + ROB_CNT_ONE;
      else if (!dispatch_fire && commit_fire)
         count_d = count_q - ROB_CNT_ONE;
   end

   // Pointer and entry updates; a flush overrides dispatch, writeback and pop
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) entry_q[i] <= '0;
      end else if (rdy_in) begin
         if (clear_branch_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) entry_q[i].busy <= 1'b0;
         end else begin
            if (alu_wb_hit) begin
               entry_q[alu_wb_tag_in].ready   <= 1'b1;
               entry_q[alu_wb_tag_in].value   <= alu_wb_value_in;
               entry_q[alu_wb_tag_in].jump_en <= alu_wb_jump_en_in;
               entry_q[alu_wb_tag_in].jump_a  <= alu_wb_jump_a_in;
            end
            if (lsb_wb_hit) begin
               entry_q[lsb_wb_tag_in].ready <= 1'b1;
               entry_q[lsb_wb_tag_in].value <= lsb_wb_value_in;
            end
            if (commit_fire) begin
               entry_q[head_q].busy <= 1'b0;
               head_q               <= idx_inc(head_q);
            end
            if (dispatch_fire) begin
               entry_q[tail_q] <= '{busy: 1'b1, ready: 1'b0, instr_id: dispatch_instr_id_in,
                                    rd: dispatch_rd_in, value: 32'h0, jump_en: 1'b0,
                                    jump_a: '0};
               tail_q          <= idx_inc(tail_q);
            end
            count_q <= count_d;
         end
      end
   end

   reorder_buffer_query_port u_query (
      .busy_vec_i     (busy_vec),
      .ready_vec_i    (ready_vec),
      .value_arr_i    (value_arr),
      .query_tag_i    (query_tag_in),
`ifdef ROB_BYPASS_EN
      .alu_wb_en_i    (alu_wb_en_in),
      .alu_wb_tag_i   (alu_wb_tag_in),
      .alu_wb_value_i (alu_wb_value_in),
      .lsb_wb_en_i    (lsb_wb_en_in),
      .lsb_wb_tag_i   (lsb_wb_tag_in),
      .lsb_wb_value_i (lsb_wb_value_in),
`endif
      .query_ready_o  (query_ready_out),
      .query_value_o  (query_value_out)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic,
// checked against an in-order queue model of the in-flight instructions.
`timescale 1ns/1ps
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic              clk_in = 1'b0;
   logic              rst_in, rdy_in;
   logic              dispatch_en_in;
   instr_id_t         dispatch_instr_id_in;
   logic [4:0]        dispatch_rd_in;
   rob_idx_t          dispatch_tag_out;
   logic              rob_full_out;
   logic              alu_wb_en_in;
   rob_idx_t          alu_wb_tag_in;
   logic [31:0]       alu_wb_value_in;
   logic              alu_wb_jump_en_in;
   logic [ADDR_W-1:0] alu_wb_jump_a_in;
   logic              lsb_wb_en_in;
   rob_idx_t          lsb_wb_tag_in;
   logic [31:0]       lsb_wb_value_in;
   rob_idx_t          query_tag_in;
   logic              query_ready_out;
   logic [31:0]       query_value_out;
   logic              rob_to_commit_en_out;
   instr_id_t         commit_instr_id_out;
   logic [4:0]        commit_rd_out;
   logic [31:0]       commit_value_out;
   logic              commit_jump_en_out;
   logic [ADDR_W-1:0] commit_jump_a_out;
   rob_idx_t          commit_tag_out;
   logic              clear_branch_in;

   reorder_buffer dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .dispatch_en_in(dispatch_en_in), .dispatch_instr_id_in(dispatch_instr_id_in),
      .dispatch_rd_in(dispatch_rd_in), .dispatch_tag_out(dispatch_tag_out),
      .rob_full_out(rob_full_out),
      .alu_wb_en_in(alu_wb_en_in), .alu_wb_tag_in(alu_wb_tag_in),
      .alu_wb_value_in(alu_wb_value_in), .alu_wb_jump_en_in(alu_wb_jump_en_in),
      .alu_wb_jump_a_in(alu_wb_jump_a_in),
      .lsb_wb_en_in(lsb_wb_en_in), .lsb_wb_tag_in(lsb_wb_tag_in),
      .lsb_wb_value_in(lsb_wb_value_in),
      .query_tag_in(query_tag_in), .query_ready_out(query_ready_out),
      .query_value_out(query_value_out),
      .rob_to_commit_en_out(rob_to_commit_en_out),
      .commit_instr_id_out(commit_instr_id_out), .commit_rd_out(commit_rd_out),
      .commit_value_out(commit_value_out), .commit_jump_en_out(commit_jump_en_out),
      .commit_jump_a_out(commit_jump_a_out), .commit_tag_out(commit_tag_out),
      .clear_branch_in(clear_branch_in)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: in-flight instructions in program order
   typedef struct {
      int                tag;
      instr_id_t         instr_id;
      logic [4:0]        rd;
      bit                ready;
      logic [31:0]       value;
      bit                jump_en;
      logic [ADDR_W-1:0] jump_a;
   } rec_t;

   rec_t m_q[$];
   int   next_tag  = 0;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_commits = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_wb(input int tag, input logic [31:0] v, input bit is_alu,
                                    input bit je, input logic [ADDR_W-1:0] ja);
      foreach (m_q[k]) begin
         if (m_q[k].tag == tag) begin
            m_q[k].ready = 1'b1;
            m_q[k].value = v;
            if (is_alu) begin
               m_q[k].jump_en = je;
               m_q[k].jump_a  = ja;
            end
         end
      end
   endfunction

   function automatic void model_query(input int t, output bit r, output logic [31:0] v);
      r = 1'b0;
      v = 32'h0;
      foreach (m_q[k]) begin
         if (m_q[k].tag == t && m_q[k].ready) begin
            r = 1'b1;
            v = m_q[k].value;
         end
      end
`ifdef ROB_BYPASS_EN
      if (lsb_wb_en_in && int'(lsb_wb_tag_in) == t) begin r = 1'b1; v = lsb_wb_value_in; end
      if (alu_wb_en_in && int'(alu_wb_tag_in) == t) begin r = 1'b1; v = alu_wb_value_in; end
`endif
   endfunction

   // Model state update at each rising edge, from the inputs held during the cycle
   always @(posedge clk_in) begin
      if (rst_in !== 1'b1) begin
         m_q.delete();
         next_tag = 0;
      end else if (rdy_in) begin
         if (clear_branch_in) begin
            m_q.delete();
            next_tag = 0;
         end else begin
            bit pop, push;
            rec_t r;
            pop  = (m_q.size() != 0) && m_q[0].ready;
            push = dispatch_en_in && (m_q.size() < ROB_DEPTH);
            if (alu_wb_en_in)
               model_wb(int'(alu_wb_tag_in), alu_wb_value_in, 1'b1, alu_wb_jump_en_in, alu_wb_jump_a_in);
            if (lsb_wb_en_in && !(alu_wb_en_in && alu_wb_tag_in == lsb_wb_tag_in))
               model_wb(int'(lsb_wb_tag_in), lsb_wb_value_in, 1'b0, 1'b0, '0);
            if (pop) void'(m_q.pop_front());
            if (push) begin
               r.tag = next_tag; r.instr_id = dispatch_instr_id_in; r.rd = dispatch_rd_in;
               r.ready = 1'b0; r.value = 32'h0; r.jump_en = 1'b0; r.jump_a = '0;
               m_q.push_back(r);
               next_tag = (next_tag + 1) % ROB_DEPTH;
            end
         end
      end
   end

   // Monitor: compare DUT outputs against the model mid-cycle
   always @(negedge clk_in) begin
      if (rst_in === 1'b1) begin
         bit          exp_c, qr;
         logic [31:0] qv;
         check("rob_full", rob_full_out, m_q.size() == ROB_DEPTH);
         check("dispatch_tag", dispatch_tag_out, next_tag);
         exp_c = rdy_in && (m_q.size() != 0) && m_q[0].ready;
         check("commit_en", rob_to_commit_en_out, exp_c);
         if (exp_c && rob_to_commit_en_out) begin
            check("commit_tag", commit_tag_out, m_q[0].tag);
            check("commit_instr_id", commit_instr_id_out, m_q[0].instr_id);
            check("commit_rd", commit_rd_out, m_q[0].rd);
            check("commit_value", commit_value_out, m_q[0].value);
            check("commit_jump_en", commit_jump_en_out, m_q[0].jump_en);
            check("commit_jump_a", commit_jump_a_out, m_q[0].jump_a);
            n_commits++;
         end
         model_query(int'(query_tag_in), qr, qv);
         check("query_ready", query_ready_out, qr);
         if (qr) check("query_value", query_value_out, qv);
      end
   end

   task automatic idle_inputs();
      rdy_in = 1'b1; dispatch_en_in = 1'b0; dispatch_instr_id_in = '0; dispatch_rd_in = '0;
      alu_wb_en_in = 1'b0; alu_wb_tag_in = '0; alu_wb_value_in = '0;
      alu_wb_jump_en_in = 1'b0; alu_wb_jump_a_in = '0;
      lsb_wb_en_in = 1'b0; lsb_wb_tag_in = '0; lsb_wb_value_in = '0;
      clear_branch_in = 1'b0;
   endtask

   task automatic cycle();
      @(posedge clk_in);
      #1;
   endtask

   task automatic dispatch_one();
      idle_inputs();
      dispatch_en_in = 1'b1;
      dispatch_instr_id_in = instr_id_t'($urandom);
      dispatch_rd_in = 5'($urandom);
      cycle();
   endtask

   task automatic alu_wb(input int tag, input logic [31:0] v, input bit je, input logic [ADDR_W-1:0] ja);
      idle_inputs();
      alu_wb_en_in = 1'b1; alu_wb_tag_in = rob_idx_t'(tag); alu_wb_value_in = v;
      alu_wb_jump_en_in = je; alu_wb_jump_a_in = ja;
      cycle();
   endtask

   task automatic lsb_wb(input int tag, input logic [31:0] v);
      idle_inputs();
      lsb_wb_en_in = 1'b1; lsb_wb_tag_in = rob_idx_t'(tag); lsb_wb_value_in = v;
      cycle();
   endtask

   task automatic flush();
      idle_inputs();
      clear_branch_in = 1'b1;
      cycle();
      idle_inputs();
   endtask

   function automatic bit pick_pending(output int tag);
      int cand[$];
      tag = 0;
      foreach (m_q[k]) if (!m_q[k].ready) cand.push_back(m_q[k].tag);
      if (cand.size() == 0) return 1'b0;
      tag = cand[$urandom_range(cand.size() - 1)];
      return 1'b1;
   endfunction

   initial begin
      int  t;
      bit  seen;
      rst_in = 1'b0;
      query_tag_in = '0;
      idle_inputs();
      repeat (2) @(negedge clk_in);
      // Reset state
      check("rst_full", rob_full_out, 0);
      check("rst_commit_en", rob_to_commit_en_out, 0);
      check("rst_dispatch_tag", dispatch_tag_out, 0);
      check("rst_commit_tag", commit_tag_out, 0);
      check("rst_commit_value", commit_value_out, 0);
      check("rst_commit_instr", commit_instr_id_out, 0);
      check("rst_commit_jump_a", commit_jump_a_out, 0);
      @(posedge clk_in); #1;
      rst_in = 1'b1;

      // Fill: 16 dispatches then one dropped
      for (int i = 0; i < 17; i++) dispatch_one();
      idle_inputs();
      check("fill_full", rob_full_out, 1);
      check("fill_tail_wrapped", dispatch_tag_out, 0);

      // Full with ready head plus dispatch: pop, dispatch dropped
      alu_wb(0, 32'h1111_0000, 1'b0, '0);
      dispatch_one();
      idle_inputs();
      check("popfull_not_full", rob_full_out, 0);
      check("popfull_tail", dispatch_tag_out, 0);
      flush();

      // Out-of-order writeback, in-order commit
      repeat (3) dispatch_one();
      lsb_wb(2, 32'h2222_2222);
      alu_wb(0, 32'h0000_0A0A, 1'b0, '0);
      idle_inputs();
      repeat (2) cycle();
      alu_wb(1, 32'h0000_0B0B, 1'b0, '0);
      idle_inputs();
      repeat (4) cycle();
      flush();

      // Branch at tag 3 with younger entries 4..7
      repeat (8) dispatch_one();
      for (int i = 4; i < 8; i++) lsb_wb(i, 32'h4000 + i);
      for (int i = 0; i < 3; i++) alu_wb(i, 32'h100 + i, 1'b0, '0);
      alu_wb(3, 32'h0000_0333, 1'b1, 32'h0000_1000);
      idle_inputs();
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_in);
         if (rob_to_commit_en_out && commit_tag_out == 3) seen = 1'b1;
      end
      check("branch_head_reached", seen, 1);
      if (seen) begin
         check("branch_jump_en", commit_jump_en_out, 1);
         check("branch_jump_a", commit_jump_a_out, 32'h1000);
         clear_branch_in = 1'b1;
         dispatch_en_in = 1'b1;
         cycle();
         idle_inputs();
         check("branch_flush_tag", dispatch_tag_out, 0);
         check("branch_flush_commit", rob_to_commit_en_out, 0);
      end

      // Query during a same-cycle ALU writeback of tag 5
      flush();
      repeat (6) dispatch_one();
      idle_inputs();
      query_tag_in = 5;
      alu_wb_en_in = 1'b1; alu_wb_tag_in = 5; alu_wb_value_in = 32'hDEAD_BEEF;
      @(negedge clk_in);
`ifdef ROB_BYPASS_EN
      check("bypass_same_cycle_ready", query_ready_out, 1);
      check("bypass_same_cycle_value", query_value_out, 32'hDEAD_BEEF);
`else
      check("nobypass_same_cycle_ready", query_ready_out, 0);
`endif
      cycle();
      idle_inputs();
      @(negedge clk_in);
      check("query_next_ready", query_ready_out, 1);
      check("query_next_value", query_value_out, 32'hDEAD_BEEF);
      cycle();
      flush();

      // Wrap: 40 dispatch/commit pairs
      for (int i = 0; i < 40; i++) begin
         idle_inputs();
         dispatch_en_in = 1'b1;
         dispatch_instr_id_in = instr_id_t'($urandom);
         dispatch_rd_in = 5'($urandom);
         if (i > 0) begin
            alu_wb_en_in = 1'b1; alu_wb_tag_in = rob_idx_t'((i - 1) % ROB_DEPTH);
            alu_wb_value_in = $urandom;
         end
         cycle();
      end
      alu_wb(39 % ROB_DEPTH, 32'h3939_3939, 1'b0, '0);
      idle_inputs();
      repeat (3) cycle();
      check("wrap_tail", dispatch_tag_out, 40 % ROB_DEPTH);
      check("wrap_empty_commit", rob_to_commit_en_out, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         rdy_in = ($urandom_range(9) != 0);
         dispatch_en_in = ($urandom_range(9) < 6);
         dispatch_instr_id_in = instr_id_t'($urandom);
         dispatch_rd_in = 5'($urandom);
         if ($urandom_range(1) == 1) begin
            alu_wb_en_in = 1'b1;
            if (!(pick_pending(t) && $urandom_range(7) != 0)) t = $urandom_range(ROB_DEPTH - 1);
            alu_wb_tag_in = rob_idx_t'(t);
            alu_wb_value_in = $urandom;
            alu_wb_jump_en_in = $urandom_range(1);
            alu_wb_jump_a_in = $urandom;
         end
         if ($urandom_range(1) == 1) begin
            lsb_wb_en_in = 1'b1;
            if (!(pick_pending(t) && $urandom_range(7) != 0)) t = $urandom_range(ROB_DEPTH - 1);
            if (alu_wb_en_in && $urandom_range(7) == 0) t = int'(alu_wb_tag_in);
            lsb_wb_tag_in = rob_idx_t'(t);
            lsb_wb_value_in = $urandom;
         end
         clear_branch_in = ($urandom_range(63) == 0);
         query_tag_in = rob_idx_t'($urandom_range(ROB_DEPTH - 1));
         cycle();
      end
      idle_inputs();
      check("commits_observed", n_commits > 100, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
